// File: rtl/sys_ctrl_rx.sv
// sys_ctrl_rx: command-frame sequencer driving the register file, the ALU and
// the transmit FIFO from bytes delivered by the receive synchronizer.
module sys_ctrl_rx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FUN_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
  input  logic                      RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]     RF_RdData,
  input  logic                      RF_RdData_VLD,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_VLD,
  input  logic                      TX_FULL,
  output logic                      RF_WrEn,
  output logic                      RF_RdEn,
  output logic [ADDR_WIDTH-1:0]     RF_Address,
  output logic [DATA_WIDTH-1:0]     RF_WrData,
  output logic                      ALU_EN,
  output logic [FUN_WIDTH-1:0]      ALU_FUN,
  output logic                      CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]     TX_P_DATA,
  output logic                      TX_D_VLD
);

  localparam int unsigned RES_WIDTH = 2 * DATA_WIDTH;

  localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_RD_SEND,
    S_ALU_A, S_ALU_B, S_ALU_FUN, S_ALU_WAIT, S_SEND_LO, S_SEND_HI
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0]   rd_q, rd_nxt;
  logic [RES_WIDTH-1:0]    res_q, res_nxt;

  logic                    wr_en_nxt, rd_en_nxt, alu_en_nxt, gate_nxt, tx_vld_nxt;
  logic [ADDR_WIDTH-1:0]   address_nxt;
  logic [DATA_WIDTH-1:0]   wr_data_nxt, tx_data_nxt;
  logic [FUN_WIDTH-1:0]    fun_nxt;

  // State, captured data and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      rd_q        <= '0;
      res_q       <= '0;
      RF_WrEn     <= 1'b0;
      RF_RdEn     <= 1'b0;
      RF_Address  <= '0;
      RF_WrData   <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr_q      <= addr_nxt;
      rd_q        <= rd_nxt;
      res_q       <= res_nxt;
      RF_WrEn     <= wr_en_nxt;
      RF_RdEn     <= rd_en_nxt;
      RF_Address  <= address_nxt;
      RF_WrData   <= wr_data_nxt;
      ALU_EN      <= alu_en_nxt;
      ALU_FUN     <= fun_nxt;
      CLK_GATE_EN <= gate_nxt;
      TX_P_DATA   <= tx_data_nxt;
      TX_D_VLD    <= tx_vld_nxt;
    end
  end

  // Frame parsing: next state and next output values.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    rd_nxt      = rd_q;
    res_nxt     = res_q;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    alu_en_nxt  = 1'b0;
    tx_vld_nxt  = 1'b0;
    address_nxt = RF_Address;
    wr_data_nxt = RF_WrData;
    fun_nxt     = ALU_FUN;
    tx_data_nxt = TX_P_DATA;

    case (state)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR)           state_nxt = S_WR_ADDR;
          else if (RX_P_DATA == CMD_RD)      state_nxt = S_RD_ADDR;
          else if (RX_P_DATA == CMD_ALU_OP)  state_nxt = S_ALU_A;
          else if (RX_P_DATA == CMD_ALU_NOP) state_nxt = S_ALU_FUN;
        end
      end
      S_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_nxt = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        // Address is presented together with the strobe, not on address arrival.
        if (RX_D_VLD) begin
          wr_en_nxt   = 1'b1;
          address_nxt = addr_q;
          wr_data_nxt = RX_P_DATA;
          state_nxt   = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          rd_en_nxt   = 1'b1;
          address_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
          state_nxt   = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (RF_RdData_VLD) begin
          rd_nxt    = RF_RdData;
          state_nxt = S_RD_SEND;
        end
      end
      S_RD_SEND: begin
        if (!TX_FULL) begin
          tx_vld_nxt  = 1'b1;
          tx_data_nxt = rd_q;
          state_nxt   = S_IDLE;
        end
      end
      S_ALU_A: begin
        if (RX_D_VLD) begin
          wr_en_nxt   = 1'b1;
          address_nxt = ADDR_WIDTH'(0);
          wr_data_nxt = RX_P_DATA;
          state_nxt   = S_ALU_B;
        end
      end
      S_ALU_B: begin
        if (RX_D_VLD) begin
          wr_en_nxt   = 1'b1;
          address_nxt = ADDR_WIDTH'(1);
          wr_data_nxt = RX_P_DATA;
          state_nxt   = S_ALU_FUN;
        end
      end
      S_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_en_nxt = 1'b1;
          fun_nxt    = RX_P_DATA[FUN_WIDTH-1:0];
          state_nxt  = S_ALU_WAIT;
        end
      end
      S_ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          res_nxt   = ALU_OUT;
          state_nxt = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        if (!TX_FULL) begin
          tx_vld_nxt  = 1'b1;
          tx_data_nxt = res_q[DATA_WIDTH-1:0];
          state_nxt   = S_SEND_HI;
        end
      end
      S_SEND_HI: begin
        if (!TX_FULL) begin
          tx_vld_nxt  = 1'b1;
          tx_data_nxt = res_q[RES_WIDTH-1:DATA_WIDTH];
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Registered gate enable tracks the state being entered.
    gate_nxt = (state_nxt == S_ALU_FUN) || (state_nxt == S_ALU_WAIT);
  end

endmodule

// File: doc/sys_ctrl_rx.md
# sys_ctrl_rx

Command sequencer between the synchronized UART receive path and the reference-clock resources. It consumes bytes delivered by the bus synchronizer as `RX_P_DATA` with a one-cycle `RX_D_VLD` strobe, and parses 8-bit command frames. It drives the register file and the ALU, including the ALU clock-gate enable, and returns read or ALU results as bytes to the transmit FIFO. All logic runs in the reference clock domain.

## Interface
- `DATA_WIDTH`, 8, width of the byte bus, the register-file data and each transmitted byte.
- `ADDR_WIDTH`, 4, register-file address width; an address byte is truncated to its low `ADDR_WIDTH` bits.
- `FUN_WIDTH`, 4, ALU function code width; a function byte is truncated to its low `FUN_WIDTH` bits.

Ports:
- `CLK` in 1: reference clock; all state changes on its rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `RX_P_DATA` in `DATA_WIDTH`: synchronized received byte.
- `RX_D_VLD` in 1: one-cycle strobe marking a new `RX_P_DATA` byte.
- `RF_RdData` in `DATA_WIDTH`: register-file read data.
- `RF_RdData_VLD` in 1: read data valid.
- `ALU_OUT` in 2*`DATA_WIDTH`: ALU result.
- `ALU_OUT_VLD` in 1: ALU result valid.
- `TX_FULL` in 1: transmit FIFO full.
- `RF_WrEn` out 1: register-file write strobe.
- `RF_RdEn` out 1: register-file read strobe.
- `RF_Address` out `ADDR_WIDTH`: register-file address.
- `RF_WrData` out `DATA_WIDTH`: register-file write data.
- `ALU_EN` out 1: ALU start strobe.
- `ALU_FUN` out `FUN_WIDTH`: ALU function code.
- `CLK_GATE_EN` out 1: ALU clock-gate enable.
- `TX_P_DATA` out `DATA_WIDTH`: byte to the transmit FIFO.
- `TX_D_VLD` out 1: transmit FIFO write strobe.

## Operation
- Every output is registered. Reset value of every output is 0, and the FSM resets to IDLE.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, SEND_LO, SEND_HI.
- IDLE, on `RX_D_VLD`, branches on the command byte:
  - 0xAA goes to WR_ADDR.
  - 0xBB goes to RD_ADDR.
  - 0xCC goes to ALU_A.
  - 0xDD goes to ALU_FUN.
  - Any other byte is dropped and the FSM stays in IDLE.
- WR_ADDR: latch the address byte, then go to WR_DATA.
- WR_DATA: on the data byte, pulse `RF_WrEn`, then go to IDLE.
- RD_ADDR: on the address byte, pulse `RF_RdEn`, then go to RD_WAIT.
- RD_WAIT: on `RF_RdData_VLD`, capture `RF_RdData`, then go to RD_SEND.
- RD_SEND: emit the captured byte, then go to IDLE.
- ALU_A: write operand A to address 0, then go to ALU_B.
- ALU_B: write operand B to address 1, then go to ALU_FUN.
- ALU_FUN: on the function byte, pulse `ALU_EN`, then go to ALU_WAIT.
- ALU_WAIT: on `ALU_OUT_VLD`, capture the 16-bit result, then go to SEND_LO.
- SEND_LO: emit bits [7:0] of the captured result, then go to SEND_HI.
- SEND_HI: emit bits [15:8] of the captured result, then go to IDLE.
- `CLK_GATE_EN` is 1 exactly while the FSM is in ALU_FUN or ALU_WAIT.
- `ALU_FUN` holds its value from the `ALU_EN` pulse until the next function byte.
- `RF_Address` and `RF_WrData` hold their last values between strobes.
- `RX_D_VLD` is ignored in RD_WAIT, RD_SEND, ALU_WAIT, SEND_LO and SEND_HI; any byte arriving then is lost.
- A second `RF_RdData_VLD` or `ALU_OUT_VLD` outside its wait state is ignored.
- Reset asserted mid-frame returns the FSM to IDLE within the same cycle (asynchronous) and clears all outputs. There is no partial-frame resume.

## Timing
- Strobe latency: `RF_WrEn`, `RF_RdEn` and `ALU_EN` rise on the clock edge following the `RX_D_VLD` cycle of the triggering byte. Each is high for exactly one cycle.
- Address and data are valid with the strobe: `RF_Address` and `RF_WrData` are valid in the same cycle as `RF_WrEn`.
- Transmit handshake:
  - In any send state, `TX_D_VLD` is 1 for one cycle at the first edge where `TX_FULL` sampled 0, with `TX_P_DATA` valid in that cycle.
  - While `TX_FULL` is 1, the FSM holds its state with `TX_D_VLD`=0.
  - SEND_LO and SEND_HI emit on consecutive cycles when `TX_FULL` stays 0.
- Read turnaround: the read byte reaches the FIFO no earlier than 1 cycle after `RF_RdData_VLD`.
- Back-to-back frames: a new command byte is accepted in the cycle the FSM re-enters IDLE.

## Test plan
- Write frame: 0xAA, 0x05, 0x3C → one-cycle `RF_WrEn` with `RF_Address`=5 and `RF_WrData`=0x3C, one cycle after the third strobe. Frame 0xAA, 0x17, 0x01 → `RF_Address`=7 (truncation).
- Read frame: 0xBB, 0x02; model returns 0x9A two cycles after `RF_RdEn` → single `TX_D_VLD` with `TX_P_DATA`=0x9A, then the FSM is in IDLE.
- ALU with operands: 0xCC, 0x0A, 0x03, 0x00; model returns `ALU_OUT`=0x000D. Required:
  - writes of 0x0A to address 0 and 0x03 to address 1;
  - `CLK_GATE_EN` high before and during `ALU_EN`, with `ALU_FUN`=0;
  - TX bytes 0x0D then 0x00 on consecutive cycles.
- ALU without operands with FIFO full: 0xDD, 0x02, result 0x1234, `TX_FULL` held high for 5 cycles → no `TX_D_VLD` while full, then 0x34 followed by 0x12.
- Robustness: unknown command 0x55 → no strobes; bytes sent during ALU_WAIT are dropped; the next 0xAA frame still executes.
- Reset mid-frame: assert `RST` low after 0xAA, 0x04 → all outputs 0. After release, 0x3C alone produces no write.
